// File: rtl/core_pkg.sv
// Shared RV32I core definitions: funct3 encodings, data-memory geometry and
// the load/store unit state type.
package core_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int DATA_MEM_ADDR_WIDTH = 12;
    localparam int REG_ADDR_WIDTH      = 5;

    localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;

    localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
    localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
    localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_e;

    function automatic logic funct3_legal(input logic is_load, input logic [2:0] funct3);
        if (is_load) begin
            return (funct3 == FUNCT3_LOAD_LB)  || (funct3 == FUNCT3_LOAD_LH) ||
                   (funct3 == FUNCT3_LOAD_LW)  || (funct3 == FUNCT3_LOAD_LBU) ||
                   (funct3 == FUNCT3_LOAD_LHU);
        end
        return funct3 <= FUNCT3_STORE_SW;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data and
// load byte/half extraction with sign or zero extension.
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_addr_lo,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    input  logic [DATA_WIDTH-1:0] i_load_word,
    output logic [3:0]            o_be,
    output logic [DATA_WIDTH-1:0] o_store_lanes,
    output logic [DATA_WIDTH-1:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    always_comb begin
        o_be          = 4'b1111;
        o_store_lanes = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                o_be          = 4'b0001 << i_addr_lo;
                o_store_lanes = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_be          = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_store_lanes = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_load_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            2'd3:    w_byte = i_load_word[31:24];
            default: ;
        endcase
        w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
    end

    always_comb begin
        o_load_data = i_load_word;
        case (i_funct3)
            FUNCT3_LOAD_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            FUNCT3_LOAD_LBU: o_load_data = {24'h0, w_byte};
            FUNCT3_LOAD_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            FUNCT3_LOAD_LHU: o_load_data = {16'h0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid data-memory transaction per op.
// Build option LSU_MISALIGN_TRAP_EN reports misaligned half/word accesses as errors.
module lsu
    import core_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int REG_ADDR_WIDTH  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       ex_valid_i,
    output logic                       ex_ready_o,
    input  logic                       ex_is_load_i,
    input  logic                       ex_is_store_i,
    input  logic [2:0]                 ex_funct3_i,
    input  logic [31:0]                ex_addr_i,
    input  logic [DATA_WIDTH-1:0]      ex_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_rd_i,

    output logic                       wb_valid_o,
    output logic                       wb_we_o,
    output logic [REG_ADDR_WIDTH-1:0]  wb_rd_o,
    output logic [DATA_WIDTH-1:0]      wb_rdata_o,
    output logic                       wb_err_o,

    output logic                       dmem_req_o,
    input  logic                       dmem_gnt_i,
    output logic                       dmem_we_o,
    output logic [3:0]                 dmem_be_o,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0]      dmem_wdata_o,
    input  logic                       dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata_i
);

    lsu_state_e                r_state;
    lsu_state_e                w_next;
    logic                      r_is_load;
    logic                      r_err;
    logic [2:0]                r_funct3;
    logic [31:0]               r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_rdata;

    logic                      w_accept;
    logic                      w_misalign;
    logic                      w_illegal;
    logic [3:0]                w_be;
    logic [DATA_WIDTH-1:0]     w_store_lanes;
    logic [DATA_WIDTH-1:0]     w_load_data;

    // Exactly one of load/store must be flagged; anything else is not a memory op.
    assign w_accept = ex_valid_i && ex_ready_o && (ex_is_load_i ^ ex_is_store_i);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((ex_funct3_i[1:0] == 2'b01) && ex_addr_i[0]) ||
                        ((ex_funct3_i[1:0] == 2'b10) && (ex_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_illegal = !funct3_legal(ex_is_load_i, ex_funct3_i) || w_misalign;

    lsu_align u_align (
        .i_funct3      (r_funct3),
        .i_addr_lo     (r_addr[1:0]),
        .i_store_data  (r_wdata),
        .i_load_word   (dmem_rdata_i),
        .o_be          (w_be),
        .o_store_lanes (w_store_lanes),
        .o_load_data   (w_load_data)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= LSU_IDLE;
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_load <= ex_is_load_i;
                r_err     <= w_illegal;
                r_funct3  <= ex_funct3_i;
                r_addr    <= ex_addr_i;
                r_wdata   <= ex_wdata_i;
                r_rd      <= ex_rd_i;
            end
            if ((r_state == LSU_WAIT) && dmem_rvalid_i) begin
                r_rdata <= w_load_data;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        ex_ready_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'b0000;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        wb_valid_o   = 1'b0;
        wb_we_o      = 1'b0;
        wb_rd_o      = '0;
        wb_rdata_o   = '0;
        wb_err_o     = 1'b0;

        case (r_state)
            LSU_IDLE: begin
                ex_ready_o = 1'b1;
                if (w_accept) begin
                    w_next = w_illegal ? LSU_RESP : LSU_REQ;
                end
            end
            LSU_REQ: begin
                // Bus fields come only from captured registers, so they hold while gnt is low.
                dmem_req_o   = 1'b1;
                dmem_we_o    = !r_is_load;
                dmem_be_o    = w_be;
                dmem_addr_o  = r_addr[DMEM_ADDR_WIDTH+1:2];
                dmem_wdata_o = r_is_load ? '0 : w_store_lanes;
                if (dmem_gnt_i) begin
                    w_next = r_is_load ? LSU_WAIT : LSU_RESP;
                end
            end
            LSU_WAIT: begin
                if (dmem_rvalid_i) begin
                    w_next = LSU_RESP;
                end
            end
            LSU_RESP: begin
                wb_valid_o = 1'b1;
                wb_we_o    = r_is_load && !r_err;
                wb_rd_o    = r_is_load ? r_rd : '0;
                wb_rdata_o = (r_is_load && !r_err) ? r_rdata : '0;
                wb_err_o   = r_err;
                w_next     = LSU_IDLE;
            end
            default: w_next = LSU_IDLE;
        endcase
    end

endmodule
